// File: rtl/reduce_pkg.sv
// reduce_pkg: shared types, field positions and widths for the reduce sampler
package reduce_pkg;

    localparam int SEQ_W    = 2;
    localparam int OUT_W    = 6;
    localparam int A_BIT    = 0;
    localparam int COUT_BIT = 1;
    localparam int CTRL_BIT = 2;
    localparam int PAR_BIT  = 3;
    localparam int SEQ_LSB  = 4;
    localparam int SEQ_MSB  = 5;

    typedef struct packed {
        logic control;
        logic cout;
        logic a;
    } tuple_t;

    function automatic logic tuple_parity(input tuple_t t);
        return ^t;
    endfunction

endpackage

// File: rtl/reduce_fifo.sv
// reduce_fifo: generic synchronous FIFO with wrap-bit read/write pointers
module reduce_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = wr_ptr_q == rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // next pointers and storage; flush rewinds both pointers and ignores traffic
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // pointer and storage registers; storage needs no reset since pointers gate it
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/reduce_sampler.sv
// reduce_sampler: tags, parity-stamps and buffers reduce-stage result tuples
module reduce_sampler
    import reduce_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_cout,
    input  logic             in_control,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] ctrl_cnt,
    output logic             dropped
);

    tuple_t             tuple;
    logic               full, empty, push, pop, par_next;
    logic [OUT_W-1:0]   entry, rdata;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               par_q, par_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;

    assign tuple     = '{control: in_control, cout: in_cout, a: in_a};
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign par_next  = par_q ^ tuple_parity(tuple);
    assign entry     = {seq_q, par_next, tuple};
    assign out_data  = out_valid ? rdata : '0;
    assign ctrl_cnt  = cnt_q;
    assign dropped   = drop_q;

    reduce_fifo #(.DEPTH(DEPTH), .WIDTH(OUT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (entry),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    // tag, running parity, saturating control counter and sticky drop flag
    always_comb begin
        seq_d  = flush ? '0 : push ? seq_q + SEQ_W'(1) : seq_q;
        par_d  = flush ? 1'b0 : push ? par_next : par_q;
        cnt_d  = (push && in_control && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        drop_d = drop_q || (in_valid && !in_ready);
    end

    // sampler state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q  <= '0;
            par_q  <= 1'b0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            par_q  <= par_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_reduce_sampler.sv
// tb_reduce_sampler: directed and random scoreboard checks of reduce_sampler
module tb_reduce_sampler;

    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_a = 1'b0, in_cout = 1'b0, in_control = 1'b0;
    logic          flush = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid, dropped;
    logic [5:0]    out_data;
    logic [CW-1:0] ctrl_cnt;

    int checks = 0;
    int errors = 0;

    logic [5:0]    q[$];
    logic [1:0]    m_seq;
    logic          m_par, m_drop;
    logic [CW-1:0] m_cnt;

    reduce_sampler #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_a       (in_a),
        .in_cout    (in_cout),
        .in_control (in_control),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .ctrl_cnt   (ctrl_cnt),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        q.delete(); m_seq = '0; m_par = 1'b0; m_cnt = '0; m_drop = 1'b0;
    endtask

    task automatic step(input logic v, input logic a, input logic c, input logic ctl,
                        input logic ordy, input logic fl);
        logic acc;
        in_valid = v; in_a = a; in_cout = c; in_control = ctl; out_ready = ordy; flush = fl;
        chk("in_ready", 8'(in_ready), 8'(q.size() != DEPTH));
        chk("out_valid", 8'(out_valid), 8'(q.size() != 0));
        chk("out_data", 8'(out_data), 8'(q.size() != 0 ? q[0] : 6'd0));
        chk("ctrl_cnt", 8'(ctrl_cnt), 8'(m_cnt));
        chk("dropped", 8'(dropped), 8'(m_drop));
        acc = v && q.size() < DEPTH;
        if (v && !acc) m_drop = 1'b1;
        if (fl) begin
            q.delete(); m_seq = '0; m_par = 1'b0;
        end else begin
            if (ordy && q.size() != 0) void'(q.pop_front());
            if (acc) begin
                m_par = m_par ^ a ^ c ^ ctl;
                q.push_back({m_seq, m_par, ctl, c, a});
                m_seq = m_seq + 2'd1;
                if (ctl && m_cnt != '1) m_cnt = m_cnt + CW'(1);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_out_data", 8'(out_data), 8'd0);
        chk("rst_ctrl_cnt", 8'(ctrl_cnt), 8'd0);
        chk("rst_dropped", 8'(dropped), 8'd0);
        step(1, 1, 0, 1, 1, 0);
        chk("first_out_valid", 8'(out_valid), 8'd1);
        chk("first_out_data", 8'(out_data), 8'b000101);
        chk("first_ctrl_cnt", 8'(ctrl_cnt), 8'd1);
        step(0, 0, 0, 0, 1, 0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 1'(i), 0, 0, 0, 0);
            if (i == 3) chk("full_in_ready", 8'(in_ready), 8'd0);
        end
        chk("overflow_dropped", 8'(dropped), 8'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_tag", 8'(out_data[5:4]), 8'(i));
            step(0, 0, 0, 0, 1, 0);
        end
        chk("drained_valid", 8'(out_valid), 8'd0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 1, 0, 0);
            chk("sat_cnt", 8'(ctrl_cnt), 8'(i < 3 ? i + 1 : 3));
        end
        step(1, 1, 1, 1, 1, 0);
        chk("full_pop_in_ready", 8'(in_ready), 8'd1);
        chk("full_pop_valid", 8'(out_valid), 8'd1);
        step(1, 0, 0, 1, 0, 0);
        chk("refill_in_ready", 8'(in_ready), 8'd0);
        chk("sat_cnt5", 8'(ctrl_cnt), 8'd3);
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 1, 0, 1);
        chk("flush_out_valid", 8'(out_valid), 8'd0);
        chk("flush_in_ready", 8'(in_ready), 8'd1);
        chk("flush_cnt_kept", 8'(ctrl_cnt), 8'd3);
        step(1, 1, 0, 0, 0, 0);
        chk("post_flush_data", 8'(out_data), 8'b001001);
        for (int i = 0; i < 3; i++) step(1, 1'(i), 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("mid_drain_valid", 8'(out_valid), 8'd1);
        do_reset();
        chk("mid_rst_out_valid", 8'(out_valid), 8'd0);
        chk("mid_rst_out_data", 8'(out_data), 8'd0);
        chk("mid_rst_ctrl_cnt", 8'(ctrl_cnt), 8'd0);
        chk("mid_rst_dropped", 8'(dropped), 8'd0);
        chk("mid_rst_in_ready", 8'(in_ready), 8'd1);
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
        end
        step(0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
